csr_machine_file: RTL and testbench
===================================

# csr_machine_file

Machine-mode CSR file for the pipelined RISC-V core, replacing the fixed 32-bit, 16-entry CSR block. It sits beside the pipeline's execute/writeback stages. It serves CSR read and write instructions, records trap state, and returns trap and mret redirect targets. It adds:
- XLEN parametrisation;
- mie/mip interrupt logic with fixed priority;
- vectored mtvec;
- mscratch;
- 64-bit mcycle/minstret counters;
- illegal-address detection.

## Interface
Parameters:
- XLEN, 32: register width; legal values 32 or 64.
- RESET_MTVEC, 0: mtvec reset value.
- MSTATUS_RST, 'h1880: mstatus reset value (MPP=11, MIE=0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- raddr  in  12  CSR read address.
- rdata  out  XLEN  read data; combinational from raddr.
- r_illegal  out  1  raddr not implemented, or an XLEN=64 read of a *h address.
- csr_w  in  1  write strobe.
- waddr  in  12  CSR write address.
- wdata  in  XLEN  write operand.
- csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 write.
- is_trap  in  1  synchronous exception commit.
- trap_pc  in  XLEN  faulting pc.
- trap_cause  in  XLEN  exception cause (bit XLEN-1 = 0).
- trap_val  in  XLEN  mtval value.
- is_mret  in  1  mret commit.
- instret  in  1  one instruction retired this cycle.
- irq_ext, irq_timer, irq_soft  in  1 each  level-sensitive interrupt lines.
- irq_take  out  1  interrupt must be taken at the next commit.
- irq_ack  in  1  pipeline takes the interrupt this cycle; trap_pc holds the interrupted pc.
- redirect_pc  out  XLEN  combinational target: trap vector if is_trap or irq_ack, else mepc.
- mstatus  out  XLEN  current mstatus.

## Operation
Implemented CSRs:
- mstatus 0x300:
  - only MIE[3], MPIE[7] and MPP[12:11] are storage;
  - MPP is read-only 11;
  - all other bits read 0.
- mie 0x304:
  - only MEIE[11], MTIE[7] and MSIE[3] are writable.
- mtvec 0x305:
  - MODE is bits [1:0]; values 0 and 1 are legal;
  - a write of 2 or 3 leaves MODE unchanged;
  - BASE is bits [XLEN-1:2].
- mscratch 0x340: full width.
- mepc 0x341: bits [1:0] always read 0.
- mcause 0x342, mtval 0x343: full width.
- mip 0x344:
  - read-only mirror of the irq lines at bits 11, 7 and 3;
  - writes are ignored.
- mcycle 0xB00, minstret 0xB02: 64-bit counters.
- mcycleh 0xB80, minstreth 0xB82: upper counter halves; exist only when XLEN=32.
- Any other address:
  - r_illegal=1 and rdata=0;
  - a write is ignored.

Interrupt logic:
- Pending vector p = mie & mip.
- irq_take = MIE & |p; combinational.
- Priority ext (cause 11) > soft (3) > timer (7).
- The interrupt cause has bit XLEN-1 set.

Trap entry, on is_trap or irq_ack:
- mepc <= trap_pc with bits [1:0] cleared.
- mcause <= trap_cause, or the interrupt cause on irq_ack.
- mtval <= trap_val, or 0 on irq_ack.
- MPIE <= MIE; MIE <= 0.
- Vector:
  - direct mode: BASE<<2;
  - vectored mode, interrupt: (BASE<<2) + 4*cause_code;
  - vectored mode, exception: BASE<<2.

mret:
- MIE <= MPIE; MPIE <= 1.
- redirect_pc = mepc.

Counters:
- mcycle increments every cycle.
- minstret increments when instret=1.
- Both wrap at 2^64-1 to 0.

Same-cycle priority: rst > trap entry (is_trap/irq_ack) > is_mret > csr_w.
- A csr_w in a trap or mret cycle is dropped.
- is_trap and irq_ack together: is_trap wins and the interrupt stays pending.
- A CSR write to a counter half replaces that half's increment in the same cycle; the other half holds.

## Timing
- All state updates on posedge clk.
- rdata, r_illegal, irq_take and redirect_pc are combinational with 0-cycle latency.
- A written value is visible on rdata in the cycle after csr_w.
- A write of MIE=1 affects irq_take from the next cycle.
- Reset values:
  - mstatus = MSTATUS_RST; mtvec = RESET_MTVEC;
  - all other storage = 0;
  - outputs follow from these (irq_take=0, mstatus='h1880).
- Reset asserted mid-operation clears state immediately, regardless of the clock. The first increment occurs on the first posedge after rst falls.

## Test plan
- Reset, then read 0x300, 0x305 and 0xB00 → 'h1880, 0, 0. After 10 idle cycles, mcycle reads 10.
- csr_w set-mode wdata=8 to 0x300. Write 'h888 to 0x304. Assert irq_timer → irq_take=1. irq_ack with trap_pc='h104 →
  - mepc='h104, mcause='h80000007;
  - MIE=0, MPIE=1;
  - irq_take=0.
- mtvec='h1001 (vectored); raise irq_ext and irq_soft together, then ack → mcause='h8000000B, redirect_pc='h102C.
- is_trap and csr_w to 0x340 in the same cycle → mscratch unchanged, mcause=trap_cause. A following is_mret → MIE=1, redirect_pc=mepc.
- mcycle preloaded to 'hFFFFFFFF (mcycleh=0), 1 cycle → mcycle=0, mcycleh=1. Write mcycleh=5 in the carry cycle → mcycleh=5.
- Read 0x7C0 → r_illegal=1, rdata=0. Write mtvec mode=2 → mode unchanged. XLEN=64 build: read 0xB80 → r_illegal=1.

Source files
------------

// File: rtl/csr_machine_file.sv
// csr_machine_file
// Machine-mode CSR file that sits beside the execute/writeback stages of the
// pipelined RISC-V core. It serves CSR reads and writes, records trap state,
// raises the interrupt request, and supplies the trap/mret redirect target.
//
// Parameters
//   XLEN         register width (32 or 64)
//   RESET_MTVEC  mtvec value after reset
//   MSTATUS_RST  mstatus value after reset (MIE/MPIE taken from bits 3/7)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   raddr -> rdata/r_illegal combinational read port
//   csr_w, waddr, wdata,
//   csr_wsc_mode             write port (00/01 write, 10 set, 11 clear)
//   is_trap, trap_pc,
//   trap_cause, trap_val     synchronous exception commit
//   is_mret                  mret commit
//   instret                  one instruction retired this cycle
//   irq_ext/timer/soft       level-sensitive interrupt lines
//   irq_take                 interrupt must be taken at the next commit
//   irq_ack                  pipeline takes the interrupt this cycle
//   redirect_pc              trap vector on trap/irq_ack, otherwise mepc
//   mstatus                  current mstatus view
module csr_machine_file #(
  parameter int          XLEN        = 32,
  parameter logic [63:0] RESET_MTVEC = 64'h0,
  parameter logic [63:0] MSTATUS_RST = 64'h1880
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            r_illegal,
  input  logic            csr_w,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      csr_wsc_mode,
  input  logic            is_trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic            is_mret,
  input  logic            instret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            irq_take,
  input  logic            irq_ack,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mstatus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  // MEIE / MTIE / MSIE positions; the same positions are used in mip.
  localparam logic [XLEN-1:0] IE_MASK = XLEN'(12'h888);

  // Architectural state
  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     mcycle_q, minstret_q;

  // Next-state values
  logic            st_mie_d, st_mpie_d;
  logic [XLEN-1:0] mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d;
  logic [63:0]     mcycle_d, minstret_d;

  logic [XLEN-1:0] mip_w;
  logic [XLEN-1:0] pend;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] irq_cause;
  logic [XLEN-1:0] vec_base;
  logic            trap_enter, take_irq;
  logic [XLEN:0]   wr_look;
  logic [XLEN-1:0] wval;
  logic            wr_en;

  // mstatus view: MPP is hard-wired to machine mode.
  always_comb begin
    mstatus       = '0;
    mstatus[12:11] = 2'b11;
    mstatus[7]    = st_mpie;
    mstatus[3]    = st_mie;
  end

  always_comb begin
    mip_w     = '0;
    mip_w[11] = irq_ext;
    mip_w[7]  = irq_timer;
    mip_w[3]  = irq_soft;
  end

  // Returns {illegal, data} for a CSR address; shared by the read port and
  // by the set/clear read-modify-write of the write port.
  function automatic logic [XLEN:0] csr_lookup(input logic [11:0] a);
    logic            ill;
    logic [XLEN-1:0] d;
    ill = 1'b0;
    d   = '0;
    case (a)
      A_MSTATUS:  d = mstatus;
      A_MIE:      d = mie_q;
      A_MTVEC:    d = mtvec_q;
      A_MSCRATCH: d = mscratch_q;
      A_MEPC:     d = mepc_q;
      A_MCAUSE:   d = mcause_q;
      A_MTVAL:    d = mtval_q;
      A_MIP:      d = mip_w;
      A_MCYCLE:   d = XLEN'(mcycle_q);
      A_MINSTRET: d = XLEN'(minstret_q);
      A_MCYCLEH: begin
        if (XLEN == 32) d = XLEN'(mcycle_q[63:32]);
        else            ill = 1'b1;
      end
      A_MINSTRETH: begin
        if (XLEN == 32) d = XLEN'(minstret_q[63:32]);
        else            ill = 1'b1;
      end
      default:    ill = 1'b1;
    endcase
    return {ill, d};
  endfunction

  assign {r_illegal, rdata} = csr_lookup(raddr);

  // Interrupt request and fixed-priority cause selection (ext > soft > timer).
  assign pend     = mie_q & mip_w;
  assign irq_take = st_mie & (|pend);

  always_comb begin
    irq_code = 4'd0;
    if (pend[11])     irq_code = 4'd11;
    else if (pend[3]) irq_code = 4'd3;
    else if (pend[7]) irq_code = 4'd7;
    irq_cause            = XLEN'(irq_code);
    irq_cause[XLEN-1]    = 1'b1;
  end

  // An exception commit outranks a simultaneous interrupt acknowledge; the
  // interrupt then simply stays pending.
  assign trap_enter = is_trap | irq_ack;
  assign take_irq   = irq_ack & ~is_trap;
  assign vec_base   = mtvec_q & ~XLEN'(3);

  always_comb begin
    redirect_pc = mepc_q;
    if (trap_enter) begin
      if (mtvec_q[0] && take_irq) redirect_pc = vec_base + XLEN'({irq_code, 2'b00});
      else                        redirect_pc = vec_base;
    end
  end

  // Write operand after set/clear merging with the current CSR value.
  assign wr_look = csr_lookup(waddr);

  always_comb begin
    case (csr_wsc_mode)
      2'b10:   wval = wr_look[XLEN-1:0] | wdata;
      2'b11:   wval = wr_look[XLEN-1:0] & ~wdata;
      default: wval = wdata;
    endcase
  end

  // Writes are dropped in trap and mret cycles and to unimplemented addresses.
  assign wr_en = csr_w & ~trap_enter & ~is_mret & ~wr_look[XLEN];

  always_comb begin
    st_mie_d   = st_mie;
    st_mpie_d  = st_mpie;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instret};

    if (trap_enter) begin
      mepc_d    = trap_pc & ~XLEN'(3);
      mcause_d  = take_irq ? irq_cause : trap_cause;
      mtval_d   = take_irq ? '0 : trap_val;
      st_mpie_d = st_mie;
      st_mie_d  = 1'b0;
    end else if (is_mret) begin
      st_mie_d  = st_mpie;
      st_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (waddr)
        A_MSTATUS: begin
          st_mie_d  = wval[3];
          st_mpie_d = wval[7];
        end
        A_MIE:      mie_d = wval & IE_MASK;
        // MODE values 2 and 3 are reserved: keep the previous MODE.
        A_MTVEC:    mtvec_d = {wval[XLEN-1:2], (wval[1] ? mtvec_q[1:0] : wval[1:0])};
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d = wval & ~XLEN'(3);
        A_MCAUSE:   mcause_d = wval;
        A_MTVAL:    mtval_d = wval;
        // A write to one counter half replaces that cycle's increment and
        // leaves the other half untouched.
        A_MCYCLE: begin
          if (XLEN == 64) mcycle_d = 64'(wval);
          else            mcycle_d = {mcycle_q[63:32], wval[31:0]};
        end
        A_MINSTRET: begin
          if (XLEN == 64) minstret_d = 64'(wval);
          else            minstret_d = {minstret_q[63:32], wval[31:0]};
        end
        A_MCYCLEH:   mcycle_d   = {wval[31:0], mcycle_q[31:0]};
        A_MINSTRETH: minstret_d = {wval[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie     <= MSTATUS_RST[3];
      st_mpie    <= MSTATUS_RST[7];
      mie_q      <= '0;
      mtvec_q    <= XLEN'(RESET_MTVEC);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      st_mie     <= st_mie_d;
      st_mpie    <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_machine_file.sv
`timescale 1ns/100ps
module tb_csr_machine_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] raddr = 12'h0;
  logic [31:0] rdata;
  logic        r_illegal;
  logic        csr_w = 1'b0;
  logic [11:0] waddr = 12'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  mode = 2'b00;
  logic        is_trap = 1'b0;
  logic [31:0] trap_pc = 32'h0, trap_cause = 32'h0, trap_val = 32'h0;
  logic        is_mret = 1'b0;
  logic        instret = 1'b0;
  logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_soft = 1'b0;
  logic        irq_take;
  logic        irq_ack = 1'b0;
  logic [31:0] redirect_pc;
  logic [31:0] mstatus;

  // Second build with XLEN=64, only its read port is exercised.
  logic [11:0] raddr64 = 12'h0;
  logic [63:0] rdata64, redirect64, mstatus64;
  logic        r_ill64, irq_take64;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  csr_machine_file #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .r_illegal(r_illegal),
    .csr_w(csr_w), .waddr(waddr), .wdata(wdata), .csr_wsc_mode(mode),
    .is_trap(is_trap), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val),
    .is_mret(is_mret), .instret(instret), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_soft(irq_soft), .irq_take(irq_take), .irq_ack(irq_ack),
    .redirect_pc(redirect_pc), .mstatus(mstatus)
  );

  csr_machine_file #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .raddr(raddr64), .rdata(rdata64), .r_illegal(r_ill64),
    .csr_w(1'b0), .waddr(12'h0), .wdata(64'h0), .csr_wsc_mode(2'b00),
    .is_trap(1'b0), .trap_pc(64'h0), .trap_cause(64'h0), .trap_val(64'h0),
    .is_mret(1'b0), .instret(1'b0), .irq_ext(1'b0), .irq_timer(1'b0),
    .irq_soft(1'b0), .irq_take(irq_take64), .irq_ack(1'b0),
    .redirect_pc(redirect64), .mstatus(mstatus64)
  );

  // ---------------- behavioural model (XLEN=32) ----------------
  bit          m_MIE, m_MPIE;
  logic [31:0] m_ie, m_tvec, m_scr, m_epc, m_cause, m_tval;
  logic [63:0] m_cyc, m_ins;
  logic [63:0] n_cyc, n_ins;
  logic [32:0] m_old;
  logic [31:0] m_v;

  task automatic m_reset();
    m_MIE = 1'b0; m_MPIE = 1'b1;
    m_ie = 0; m_tvec = 0; m_scr = 0; m_epc = 0; m_cause = 0; m_tval = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [31:0] m_mstatus();
    return 32'h1800 | (m_MPIE ? 32'h80 : 32'h0) | (m_MIE ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] m_mip();
    return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) | (irq_soft ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mstatus()};
      12'h304: return {1'b0, m_ie};
      12'h305: return {1'b0, m_tvec};
      12'h340: return {1'b0, m_scr};
      12'h341: return {1'b0, m_epc};
      12'h342: return {1'b0, m_cause};
      12'h343: return {1'b0, m_tval};
      12'h344: return {1'b0, m_mip()};
      12'hB00: return {1'b0, m_cyc[31:0]};
      12'hB02: return {1'b0, m_ins[31:0]};
      12'hB80: return {1'b0, m_cyc[63:32]};
      12'hB82: return {1'b0, m_ins[63:32]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic int m_code();
    logic [31:0] p;
    p = m_ie & m_mip();
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    return 0;
  endfunction

  function automatic bit m_take();
    return m_MIE && ((m_ie & m_mip()) != 0);
  endfunction

  function automatic logic [31:0] m_redirect();
    logic [31:0] base;
    base = {m_tvec[31:2], 2'b00};
    if (is_trap) return base;
    if (irq_ack) return (m_tvec[1:0] == 2'b01) ? base + 32'(4 * m_code()) : base;
    return m_epc;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      n_cyc = m_cyc + 64'd1;
      n_ins = m_ins + (instret ? 64'd1 : 64'd0);
      if (is_trap || irq_ack) begin
        m_epc   = trap_pc & 32'hFFFF_FFFC;
        m_cause = is_trap ? trap_cause : (32'h8000_0000 | 32'(m_code()));
        m_tval  = is_trap ? trap_val : 32'h0;
        m_MPIE  = m_MIE;
        m_MIE   = 1'b0;
      end else if (is_mret) begin
        m_MIE  = m_MPIE;
        m_MPIE = 1'b1;
      end else if (csr_w) begin
        m_old = m_read(waddr);
        m_v = (mode == 2'b10) ? (m_old[31:0] | wdata) :
              (mode == 2'b11) ? (m_old[31:0] & ~wdata) : wdata;
        case (waddr)
          12'h300: begin m_MIE = m_v[3]; m_MPIE = m_v[7]; end
          12'h304: m_ie = m_v & 32'h888;
          12'h305: if (m_v[1:0] < 2) m_tvec = m_v; else m_tvec = {m_v[31:2], m_tvec[1:0]};
          12'h340: m_scr = m_v;
          12'h341: m_epc = m_v & 32'hFFFF_FFFC;
          12'h342: m_cause = m_v;
          12'h343: m_tval = m_v;
          12'hB00: n_cyc = {m_cyc[63:32], m_v};
          12'hB80: n_cyc = {m_v, m_cyc[31:0]};
          12'hB02: n_ins = {m_ins[63:32], m_v};
          12'hB82: n_ins = {m_v, m_ins[31:0]};
          default: ;
        endcase
      end
      m_cyc = n_cyc;
      m_ins = n_ins;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [32:0] e_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      e_rd = m_read(raddr);
      chk("cmp_rdata", 64'(rdata), 64'(e_rd[31:0]));
      chk("cmp_r_illegal", 64'(r_illegal), 64'(e_rd[32]));
      chk("cmp_irq_take", 64'(irq_take), 64'(m_take()));
      chk("cmp_redirect_pc", 64'(redirect_pc), 64'(m_redirect()));
      chk("cmp_mstatus", 64'(mstatus), 64'(m_mstatus()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #0.5;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] m);
    csr_w = 1'b1; waddr = a; wdata = d; mode = m;
    tick();
    csr_w = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] e);
    raddr = a; settle();
    chk(nm, 64'(rdata), 64'(e));
  endtask

  logic [11:0] addr_tab [15] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                 12'h7C0, 12'h001, 12'hB81};

  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state and first increments
    rd("rst_mstatus", 12'h300, 32'h1880);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mcycle", 12'hB00, 32'h0);
    chk("rst_irq_take", 64'(irq_take), 64'h0);
    chk("rst_mstatus_port", 64'(mstatus), 64'h1880);
    repeat (10) tick();
    rd("mcycle_10", 12'hB00, 32'd10);

    // Timer interrupt, direct mode
    wr(12'h300, 32'h8, 2'b10);
    wr(12'h304, 32'h888, 2'b01);
    rd("mstatus_mie", 12'h300, 32'h1888);
    irq_timer = 1'b1; settle();
    chk("timer_take", 64'(irq_take), 64'h1);
    irq_ack = 1'b1; trap_pc = 32'h104; settle();
    chk("timer_redirect", 64'(redirect_pc), 64'h0);
    tick();
    irq_ack = 1'b0;
    rd("timer_mepc", 12'h341, 32'h104);
    rd("timer_mcause", 12'h342, 32'h8000_0007);
    chk("timer_mstatus", 64'(mstatus), 64'h1880);
    chk("timer_take_off", 64'(irq_take), 64'h0);
    irq_timer = 1'b0;

    // Vectored mode, ext beats soft
    wr(12'h305, 32'h1001, 2'b01);
    wr(12'h300, 32'h8, 2'b10);
    irq_ext = 1'b1; irq_soft = 1'b1; settle();
    chk("ext_take", 64'(irq_take), 64'h1);
    irq_ack = 1'b1; trap_pc = 32'h200; settle();
    chk("ext_redirect", 64'(redirect_pc), 64'h102C);
    tick();
    irq_ack = 1'b0; irq_ext = 1'b0; irq_soft = 1'b0;
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    rd("ext_mtval", 12'h343, 32'h0);

    // Exception with a colliding CSR write, then mret
    wr(12'h340, 32'hA5A5, 2'b01);
    wr(12'h300, 32'h8, 2'b10);
    is_trap = 1'b1; trap_cause = 32'h2; trap_pc = 32'h301; trap_val = 32'hDEAD;
    csr_w = 1'b1; waddr = 12'h340; wdata = 32'h1234; mode = 2'b01; settle();
    chk("exc_redirect", 64'(redirect_pc), 64'h1000);
    tick();
    is_trap = 1'b0; csr_w = 1'b0;
    rd("exc_mscratch", 12'h340, 32'hA5A5);
    rd("exc_mcause", 12'h342, 32'h2);
    rd("exc_mtval", 12'h343, 32'hDEAD);
    rd("exc_mepc", 12'h341, 32'h300);
    chk("exc_mstatus", 64'(mstatus), 64'h1880);
    is_mret = 1'b1; csr_w = 1'b1; waddr = 12'h340; wdata = 32'h77; settle();
    chk("mret_redirect", 64'(redirect_pc), 64'h300);
    tick();
    is_mret = 1'b0; csr_w = 1'b0;
    chk("mret_mstatus", 64'(mstatus), 64'h1888);
    rd("mret_mscratch", 12'h340, 32'hA5A5);

    // Counter carry, half writes, 64-bit wrap, minstret
    wr(12'hB80, 32'h0, 2'b01);
    wr(12'hB00, 32'hFFFF_FFFF, 2'b01);
    rd("pre_lo", 12'hB00, 32'hFFFF_FFFF);
    rd("pre_hi", 12'hB80, 32'h0);
    tick();
    rd("carry_lo", 12'hB00, 32'h0);
    rd("carry_hi", 12'hB80, 32'h1);
    wr(12'hB80, 32'h0, 2'b01);
    wr(12'hB00, 32'hFFFF_FFFF, 2'b01);
    wr(12'hB80, 32'h5, 2'b01);
    rd("hwr_hi", 12'hB80, 32'h5);
    rd("hwr_lo", 12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF, 2'b01);
    wr(12'hB00, 32'hFFFF_FFFF, 2'b01);
    tick();
    rd("wrap_lo", 12'hB00, 32'h0);
    rd("wrap_hi", 12'hB80, 32'h0);
    rd("ins_idle", 12'hB02, 32'h0);
    instret = 1'b1;
    repeat (3) tick();
    rd("ins_3", 12'hB02, 32'd3);
    wr(12'hB02, 32'h10, 2'b01);
    rd("ins_wr", 12'hB02, 32'h10);
    instret = 1'b0;

    // Illegal address, reserved mtvec modes, read-only / masked fields
    raddr = 12'h7C0; settle();
    chk("ill_flag", 64'(r_illegal), 64'h1);
    chk("ill_data", 64'(rdata), 64'h0);
    wr(12'h305, 32'h2002, 2'b01);
    rd("mtvec_mode2", 12'h305, 32'h2001);
    wr(12'h305, 32'h2, 2'b10);
    rd("mtvec_set3", 12'h305, 32'h2001);
    wr(12'h344, 32'hFFF, 2'b01);
    rd("mip_ro", 12'h344, 32'h0);
    wr(12'h341, 32'h12347, 2'b01);
    rd("mepc_align", 12'h341, 32'h12344);
    wr(12'h304, 32'hFFFF_FFFF, 2'b01);
    rd("mie_mask", 12'h304, 32'h888);
    wr(12'h304, 32'h80, 2'b11);
    rd("mie_clear", 12'h304, 32'h808);
    wr(12'h7C0, 32'h1, 2'b01);
    rd("ill_write", 12'h7C0, 32'h0);

    // XLEN=64 build read port
    raddr64 = 12'hB80; settle();
    chk("x64_mcycleh_ill", 64'(r_ill64), 64'h1);
    raddr64 = 12'hB82; settle();
    chk("x64_minstreth_ill", 64'(r_ill64), 64'h1);
    raddr64 = 12'h300; settle();
    chk("x64_mstatus_ok", 64'(r_ill64), 64'h0);
    chk("x64_mstatus", rdata64, 64'h1880);

    // Asynchronous reset mid-cycle
    tick();
    raddr = 12'hB00;
    #2 rst = 1'b1; settle();
    chk("arst_mcycle", 64'(rdata), 64'h0);
    chk("arst_mstatus", 64'(mstatus), 64'h1880);
    tick();
    rst = 1'b0;

    // Randomized traffic checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) irq_ext   = ~irq_ext;
      if ($urandom_range(7) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(7) == 0) irq_soft  = ~irq_soft;
      is_trap    = ($urandom_range(15) == 0);
      irq_ack    = m_take() && ($urandom_range(2) == 0);
      is_mret    = ($urandom_range(15) == 0);
      csr_w      = $urandom_range(1);
      waddr      = addr_tab[$urandom_range(14)];
      raddr      = addr_tab[$urandom_range(14)];
      mode       = 2'($urandom_range(3));
      wdata      = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      instret    = $urandom_range(1);
      trap_pc    = $urandom;
      trap_cause = $urandom & 32'h7FFF_FFFF;
      trap_val   = $urandom;
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    csr_w = 1'b0; is_trap = 1'b0; is_mret = 1'b0; irq_ack = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
